// File: rtl/pic_ctrl_sync.sv
// Single-clock 8259-style interrupt controller core: ICW init, OCW control, IRR/ISR, priority, INTA vectoring.
// Optional auto-EOI support is enabled by defining PIC_AEOI_EN.
module pic_ctrl_sync #(
    parameter int N_IRQ    = 8,
    parameter bit EDGE_RST = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_n,
    input  logic             rd_n,
    input  logic             a0,
    input  logic [7:0]       din,
    output logic [7:0]       dout,
    output logic             dout_en,
    input  logic [N_IRQ-1:0] irq,
    input  logic             inta_n,
    output logic             intr
);
    localparam int IDW = $clog2(N_IRQ);
    localparam int BW  = 8 - IDW;
`ifdef PIC_AEOI_EN
    localparam logic AEOI_EN = 1'b1;
`else
    localparam logic AEOI_EN = 1'b0;
`endif

    typedef enum logic [1:0] {ICW1_S, ICW2_S, ICW4_S, READY_S} init_t;
    typedef enum logic [1:0] {A_IDLE, A_P1, A_GAP, A_P2} ack_t;

    init_t            init_st, init_nxt;
    ack_t             ack_st, ack_nxt;
    logic             wr_n_q, inta_n_q;
    logic [N_IRQ-1:0] irq_q, irr, isr, imr, irr_nxt, isr_nxt;
    logic [IDW-1:0]   lp, lp_nxt, ack_id;
    logic [BW-1:0]    base;
    logic             ltim, ic4, rd_sel, aeoi, rot_aeoi, ack_spur;

    // Returns {found, id} of the highest-priority set bit; priority starts at p+1 and descends cyclically.
    function automatic logic [IDW:0] pick(input logic [N_IRQ-1:0] v, input logic [IDW-1:0] p);
        logic [IDW:0]   r;
        logic [IDW-1:0] idx;
        r = '0;
        for (int k = N_IRQ-1; k >= 0; k--) begin
            idx = p + IDW'(1) + IDW'(k);
            if (v[idx]) r = {1'b1, idx};
        end
        return r;
    endfunction

    function automatic logic [IDW-1:0] rank(input logic [IDW-1:0] id, input logic [IDW-1:0] p);
        return id - p - IDW'(1);
    endfunction

    logic           wr_ev, inta_fall, inta_rise;
    logic           icw1_ev, icw2_ev, icw4_ev, ocw1_ev, ocw2_ev, ocw3_ev;
    logic           ack_cap, ack_end, req_ok;
    logic [IDW:0]   req, isr_top;
    logic [IDW-1:0] req_id, isr_id, din_id;
    logic           unused_bits;

    assign wr_ev     = !wr_n && wr_n_q;
    assign inta_fall = !inta_n && inta_n_q;
    assign inta_rise = inta_n && !inta_n_q;
    assign icw1_ev   = wr_ev && !a0 && din[4];
    assign icw2_ev   = wr_ev && a0 && (init_st == ICW2_S);
    assign icw4_ev   = wr_ev && a0 && (init_st == ICW4_S);
    assign ocw1_ev   = wr_ev && a0 && (init_st == READY_S);
    assign ocw2_ev   = wr_ev && !a0 && !din[4] && !din[3] && (init_st == READY_S);
    assign ocw3_ev   = wr_ev && !a0 && !din[4] && din[3] && !din[7] && (init_st == READY_S);
    assign ack_cap   = !icw1_ev && (ack_st == A_IDLE) && inta_fall;
    assign ack_end   = !icw1_ev && (ack_st == A_P2) && inta_rise;
    assign din_id    = din[IDW-1:0];
    assign unused_bits = ^din;

    assign req     = pick(irr & ~imr, lp);
    assign isr_top = pick(isr, lp);
    assign req_id  = req[IDW-1:0];
    assign isr_id  = isr_top[IDW-1:0];
    // Fully nested: a request must strictly outrank every in-service level.
    assign req_ok  = req[IDW] && (!isr_top[IDW] || (rank(req_id, lp) < rank(isr_id, lp)));

    always_comb begin
        init_nxt = init_st;
        ack_nxt  = ack_st;
        irr_nxt  = ltim ? irq : (irr | (irq & ~irq_q));
        isr_nxt  = isr;
        lp_nxt   = lp;
        if (icw1_ev) begin
            init_nxt = ICW2_S;
            ack_nxt  = A_IDLE;
            isr_nxt  = '0;
            lp_nxt   = IDW'(N_IRQ-1);
        end else begin
            if (icw2_ev)      init_nxt = ic4 ? ICW4_S : READY_S;
            else if (icw4_ev) init_nxt = READY_S;
            case (ack_st)
                A_IDLE:  if (inta_fall) ack_nxt = A_P1;
                A_P1:    if (inta_rise) ack_nxt = A_GAP;
                A_GAP:   if (inta_fall) ack_nxt = A_P2;
                default: if (inta_rise) ack_nxt = A_IDLE;
            endcase
            if (ocw2_ev) begin
                case (din[7:5])
                    3'b001: if (isr_top[IDW]) isr_nxt[isr_id] = 1'b0;
                    3'b101: if (isr_top[IDW]) begin
                        isr_nxt[isr_id] = 1'b0;
                        lp_nxt = isr_id;
                    end
                    3'b011: isr_nxt[din_id] = 1'b0;
                    3'b111: if (|isr) begin
                        isr_nxt[din_id] = 1'b0;
                        lp_nxt = din_id;
                    end
                    3'b110: lp_nxt = din_id;
                    default: ;
                endcase
            end
            if (ack_cap && req_ok) begin
                isr_nxt[req_id] = 1'b1;
                irr_nxt[req_id] = 1'b0;
            end
            if (ack_end && aeoi && !ack_spur) begin
                isr_nxt[ack_id] = 1'b0;
                if (rot_aeoi) lp_nxt = ack_id;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            init_st <= ICW1_S;
            ack_st  <= A_IDLE;
        end else begin
            init_st <= init_nxt;
            ack_st  <= ack_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_n_q   <= 1'b1;
            inta_n_q <= 1'b1;
            irq_q    <= '0;
            irr      <= '0;
            isr      <= '0;
            imr      <= '0;
            lp       <= IDW'(N_IRQ-1);
            ltim     <= EDGE_RST;
            ic4      <= 1'b0;
            rd_sel   <= 1'b0;
            aeoi     <= 1'b0;
            rot_aeoi <= 1'b0;
            base     <= '0;
            ack_id   <= '0;
            ack_spur <= 1'b0;
            dout     <= '0;
            dout_en  <= 1'b0;
            intr     <= 1'b0;
        end else begin
            wr_n_q   <= wr_n;
            inta_n_q <= inta_n;
            irq_q    <= irq;
            irr      <= irr_nxt;
            isr      <= isr_nxt;
            lp       <= lp_nxt;
            if (icw1_ev) begin
                ic4    <= din[0];
                ltim   <= din[3];
                imr    <= '0;
                rd_sel <= 1'b0;
                aeoi   <= 1'b0;
            end else begin
                if (icw2_ev) base <= din[7:IDW];
                if (icw4_ev) aeoi <= AEOI_EN & din[1];
                if (ocw1_ev) imr  <= din[N_IRQ-1:0];
                if (ocw2_ev && din[6:5] == 2'b00) rot_aeoi <= AEOI_EN & din[7];
                if (ocw3_ev && din[1]) rd_sel <= din[0];
            end
            if (ack_cap) begin
                ack_id   <= req_ok ? req_id : IDW'(N_IRQ-1);
                ack_spur <= !req_ok;
            end
            intr <= (icw1_ev || ack_cap) ? 1'b0 : ((init_st == READY_S) && req_ok);
            // The vector phase owns the bus; CPU reads only get it otherwise.
            if (ack_nxt == A_P2) begin
                dout    <= {base, ack_id};
                dout_en <= 1'b1;
            end else if (!rd_n) begin
                dout    <= a0 ? 8'(imr) : 8'(rd_sel ? isr : irr);
                dout_en <= 1'b1;
            end else begin
                dout_en <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_pic_ctrl_sync.sv
// Directed bench for pic_ctrl_sync: init, nesting, rotation, masking, spurious, ICW1 abort, AEOI, async reset.
module tb_pic_ctrl_sync;
    logic       clk = 1'b0, rst_n = 1'b0, wr_n = 1'b1, rd_n = 1'b1, a0 = 1'b0, inta_n = 1'b1;
    logic [7:0] din = 8'h00;
    logic [7:0] irq = 8'h00;
    logic [7:0] dout;
    logic       dout_en, intr;
    int         n_vec = 0, n_bad = 0;

    pic_ctrl_sync #(.N_IRQ(8), .EDGE_RST(1'b0)) dut (
        .clk(clk), .rst_n(rst_n), .wr_n(wr_n), .rd_n(rd_n), .a0(a0), .din(din),
        .dout(dout), .dout_en(dout_en), .irq(irq), .inta_n(inta_n), .intr(intr)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wr(input logic a, input logic [7:0] d);
        @(negedge clk); wr_n = 1'b0; a0 = a; din = d;
        @(negedge clk); wr_n = 1'b1;
    endtask

    task automatic rd(input logic a, output logic [7:0] d, output logic en);
        @(negedge clk); rd_n = 1'b0; a0 = a;
        @(negedge clk); d = dout; en = dout_en; rd_n = 1'b1;
    endtask

    task automatic inta(output logic [7:0] v, output logic en);
        @(negedge clk); inta_n = 1'b0;
        @(negedge clk); inta_n = 1'b1;
        @(negedge clk); inta_n = 1'b0;
        @(negedge clk); v = dout; en = dout_en; inta_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset;
        logic [7:0] d; logic en;
        tick(2);
        n_vec++; if (intr !== 1'b0)    begin n_bad++; $display("FAIL rst_intr: got %b want 0", intr); end
        n_vec++; if (dout !== 8'h00)   begin n_bad++; $display("FAIL rst_dout: got %h want 00", dout); end
        n_vec++; if (dout_en !== 1'b0) begin n_bad++; $display("FAIL rst_douten: got %b want 0", dout_en); end
        rst_n = 1'b1;
        rd(1'b1, d, en);
        n_vec++; if (d !== 8'h00 || en !== 1'b1) begin n_bad++; $display("FAIL rst_imr: got %h/%b want 00/1", d, en); end
        rd(1'b0, d, en);
        n_vec++; if (d !== 8'h00) begin n_bad++; $display("FAIL rst_irr: got %h want 00", d); end
    endtask

    task automatic test_basic;
        logic [7:0] d; logic en;
        wr(1'b0, 8'h13); wr(1'b1, 8'h40); wr(1'b1, 8'h01); wr(1'b1, 8'h00);
        @(negedge clk); irq[3] = 1'b1;
        @(negedge clk);
        n_vec++; if (intr !== 1'b0) begin n_bad++; $display("FAIL basic_intr_t1: got %b want 0", intr); end
        @(negedge clk);
        n_vec++; if (intr !== 1'b1) begin n_bad++; $display("FAIL basic_intr_t2: got %b want 1", intr); end
        inta(d, en);
        n_vec++; if (d !== 8'h43 || en !== 1'b1) begin n_bad++; $display("FAIL basic_vec: got %h/%b want 43/1", d, en); end
        n_vec++; if (intr !== 1'b0) begin n_bad++; $display("FAIL basic_intr_ack: got %b want 0", intr); end
        wr(1'b0, 8'h0B);
        rd(1'b0, d, en);
        n_vec++; if (d !== 8'h08) begin n_bad++; $display("FAIL basic_isr: got %h want 08", d); end
    endtask

    task automatic test_nested;
        logic [7:0] d; logic en;
        @(negedge clk); irq[5] = 1'b1;
        tick(2);
        n_vec++; if (intr !== 1'b0) begin n_bad++; $display("FAIL nest_ir5_blocked: got %b want 0", intr); end
        @(negedge clk); irq[1] = 1'b1;
        tick(2);
        n_vec++; if (intr !== 1'b1) begin n_bad++; $display("FAIL nest_ir1_intr: got %b want 1", intr); end
        inta(d, en);
        n_vec++; if (d !== 8'h41) begin n_bad++; $display("FAIL nest_vec1: got %h want 41", d); end
        wr(1'b0, 8'h20);
        rd(1'b0, d, en);
        n_vec++; if (d !== 8'h08) begin n_bad++; $display("FAIL nest_nseoi: got %h want 08", d); end
        wr(1'b0, 8'h20);
        tick(2);
        n_vec++; if (intr !== 1'b1) begin n_bad++; $display("FAIL nest_ir5_release: got %b want 1", intr); end
        inta(d, en);
        n_vec++; if (d !== 8'h45) begin n_bad++; $display("FAIL nest_vec5: got %h want 45", d); end
        wr(1'b0, 8'h65);
        rd(1'b0, d, en);
        n_vec++; if (d !== 8'h00) begin n_bad++; $display("FAIL nest_seoi: got %h want 00", d); end
        irq = 8'h00;
    endtask

    task automatic test_rotate;
        logic [7:0] d; logic en;
        wr(1'b0, 8'hC4);
        @(negedge clk); irq[2] = 1'b1; irq[6] = 1'b1;
        tick(2);
        inta(d, en);
        n_vec++; if (d !== 8'h46) begin n_bad++; $display("FAIL rot_vec6: got %h want 46", d); end
        wr(1'b0, 8'hA0);
        @(negedge clk); irq[7] = 1'b1;
        tick(2);
        inta(d, en);
        n_vec++; if (d !== 8'h47) begin n_bad++; $display("FAIL rot_vec7: got %h want 47", d); end
        wr(1'b0, 8'h20);
        inta(d, en);
        n_vec++; if (d !== 8'h42) begin n_bad++; $display("FAIL rot_vec2: got %h want 42", d); end
        wr(1'b0, 8'h20);
        rd(1'b0, d, en);
        n_vec++; if (d !== 8'h00) begin n_bad++; $display("FAIL rot_isr: got %h want 00", d); end
        irq = 8'h00;
        wr(1'b0, 8'hC7);
    endtask

    task automatic test_mask;
        logic [7:0] d; logic en;
        wr(1'b1, 8'hFF);
        @(negedge clk); irq[0] = 1'b1;
        tick(2);
        n_vec++; if (intr !== 1'b0) begin n_bad++; $display("FAIL mask_intr: got %b want 0", intr); end
        wr(1'b0, 8'h0A);
        rd(1'b0, d, en);
        n_vec++; if (d !== 8'h01) begin n_bad++; $display("FAIL mask_irr: got %h want 01", d); end
        wr(1'b0, 8'h0B);
        rd(1'b0, d, en);
        n_vec++; if (d !== 8'h00) begin n_bad++; $display("FAIL mask_isr: got %h want 00", d); end
        rd(1'b1, d, en);
        n_vec++; if (d !== 8'hFF) begin n_bad++; $display("FAIL mask_imr: got %h want ff", d); end
    endtask

    task automatic test_spurious;
        logic [7:0] d; logic en;
        inta(d, en);
        n_vec++; if (d !== 8'h47 || en !== 1'b1) begin n_bad++; $display("FAIL spur_vec: got %h/%b want 47/1", d, en); end
        rd(1'b0, d, en);
        n_vec++; if (d !== 8'h00) begin n_bad++; $display("FAIL spur_isr: got %h want 00", d); end
    endtask

    task automatic test_icw1_abort;
        logic [7:0] d; logic en;
        wr(1'b1, 8'h00);
        tick(2);
        n_vec++; if (intr !== 1'b1) begin n_bad++; $display("FAIL abort_intr_pre: got %b want 1", intr); end
        @(negedge clk); inta_n = 1'b0;
        @(negedge clk); inta_n = 1'b1;
        wr(1'b0, 8'h13);
        n_vec++; if (intr !== 1'b0) begin n_bad++; $display("FAIL abort_intr: got %b want 0", intr); end
        wr(1'b1, 8'h40); wr(1'b1, 8'h03);
        wr(1'b0, 8'h0B);
        rd(1'b0, d, en);
        n_vec++; if (d !== 8'h00) begin n_bad++; $display("FAIL abort_isr: got %h want 00", d); end
        rd(1'b1, d, en);
        n_vec++; if (d !== 8'h00) begin n_bad++; $display("FAIL abort_imr: got %h want 00", d); end
        inta(d, en);
        n_vec++; if (d !== 8'h47 || en !== 1'b1) begin n_bad++; $display("FAIL abort_idle_vec: got %h/%b want 47/1", d, en); end
    endtask

    task automatic test_aeoi;
        logic [7:0] d; logic en;
        logic [7:0] want;
`ifdef PIC_AEOI_EN
        want = 8'h00;
`else
        want = 8'h04;
`endif
        @(negedge clk); irq[2] = 1'b1;
        tick(2);
        inta(d, en);
        n_vec++; if (d !== 8'h42) begin n_bad++; $display("FAIL aeoi_vec: got %h want 42", d); end
        rd(1'b0, d, en);
        n_vec++; if (d !== want) begin n_bad++; $display("FAIL aeoi_isr: got %h want %h", d, want); end
    endtask

    task automatic test_reset_mid;
        @(negedge clk); irq[1] = 1'b1;
        tick(2);
        n_vec++; if (intr !== 1'b1) begin n_bad++; $display("FAIL midrst_pre: got %b want 1", intr); end
        @(negedge clk); #2 rst_n = 1'b0;
        #1;
        n_vec++; if (intr !== 1'b0 || dout_en !== 1'b0 || dout !== 8'h00) begin
            n_bad++; $display("FAIL midrst_outs: got %b/%b/%h want 0/0/00", intr, dout_en, dout);
        end
        tick(1);
        rst_n = 1'b1;
    endtask

    initial begin
        test_reset;
        test_basic;
        test_nested;
        test_rotate;
        test_mask;
        test_spurious;
        test_icw1_abort;
        test_aeoi;
        test_reset_mid;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
